// File: rtl/fc_pkg.sv
// Shared constants and FSM state type for the FC layer sharing arbiter.
package fc_pkg;

    localparam int DIM_INPUT  = 96;
    localparam int DIM_OUTPUT = 8;
    localparam int INPUT_W    = 16;
    localparam int OUTPUT_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } fc_state_t;

endpackage

// File: rtl/fc_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through reads.
// A push and a pop in the same cycle both take effect, even when full.
module fc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage; cleared on reset so no stale entry is ever visible at the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fc_share_arb.sv
// Shares one FC layer between several requesters: round-robin grants whole
// samples, forwards beats, and routes results back in issue order by tag.
module fc_share_arb #(
    parameter int DIM_INPUT  = fc_pkg::DIM_INPUT,
    parameter int DIM_OUTPUT = fc_pkg::DIM_OUTPUT,
    parameter int INPUT_W    = fc_pkg::INPUT_W,
    parameter int OUTPUT_W   = fc_pkg::OUTPUT_W,
    parameter int N_REQ      = 2,
    parameter int RES_DEPTH  = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_REQ-1:0]                    rq_req,
    output logic [N_REQ-1:0]                    rq_gnt,
    input  logic [N_REQ-1:0][INPUT_W-1:0]       rq_dat,
    input  logic [N_REQ-1:0]                    rq_vld,
    output logic [INPUT_W-1:0]                  fc_dat_i,
    output logic                                fc_vld_i,
    input  logic [DIM_OUTPUT-1:0][OUTPUT_W-1:0] fc_dat_o,
    input  logic                                fc_vld_o,
    output logic [DIM_OUTPUT-1:0][OUTPUT_W-1:0] rs_dat,
    output logic [N_REQ-1:0]                    rs_vld,
    input  logic [N_REQ-1:0]                    rs_rdy,
    output logic                                busy,
    output logic                                err_unexp
);

    localparam int TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BEAT_W = $clog2(DIM_INPUT);
    localparam int CRED_W = $clog2(RES_DEPTH + 1);
    localparam int DATA_W = DIM_OUTPUT * OUTPUT_W;
    localparam int RES_W  = TAG_W + DATA_W;

    fc_pkg::fc_state_t  state;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   last_winner;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [CRED_W-1:0]  credits;

    logic [TAG_W-1:0]   rr_winner;
    logic               rr_found;
    int                 cand;
    logic               grant_fire;
    logic               beat_fire;
    logic               rs_hs;

    logic [TAG_W-1:0]   tag_head;
    logic               tag_full;
    logic               tag_empty;
    logic               tag_pop;
    logic [RES_W-1:0]   res_head;
    logic               res_full;
    logic               res_empty;
    logic               res_push;

    // Round-robin search starting just after the last requester that completed a sample.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_winner;
        cand      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_winner) + i) % N_REQ;
            if (!rr_found && rq_req[cand]) begin
                rr_found  = 1'b1;
                rr_winner = TAG_W'(cand);
            end
        end
    end

    assign grant_fire = (state == fc_pkg::IDLE) && rr_found && (credits != '0) && !tag_full;
    assign beat_fire  = (state == fc_pkg::FEED) && rq_vld[grant_idx];
    assign rs_hs      = |(rs_vld & rs_rdy);

    // Grant/feed sequencer with registered grant and forwarded beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= fc_pkg::IDLE;
            rq_gnt      <= '0;
            grant_idx   <= '0;
            last_winner <= TAG_W'(N_REQ - 1);
            beat_cnt    <= '0;
            fc_vld_i    <= 1'b0;
            fc_dat_i    <= '0;
        end else begin
            fc_vld_i <= 1'b0;
            case (state)
                fc_pkg::IDLE: begin
                    if (grant_fire) begin
                        state     <= fc_pkg::FEED;
                        grant_idx <= rr_winner;
                        rq_gnt    <= N_REQ'(1) << rr_winner;
                        beat_cnt  <= '0;
                    end
                end
                fc_pkg::FEED: begin
                    if (beat_fire) begin
                        fc_vld_i <= 1'b1;
                        fc_dat_i <= rq_dat[grant_idx];
                        if (beat_cnt == BEAT_W'(DIM_INPUT - 1)) begin
                            state       <= fc_pkg::IDLE;
                            rq_gnt      <= '0;
                            last_winner <= grant_idx;
                            beat_cnt    <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= fc_pkg::IDLE;
            endcase
        end
    end

    // One credit per result slot: taken at grant, returned when the requester takes its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CRED_W'(RES_DEPTH);
        end else begin
            case ({grant_fire, rs_hs})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky error when the FC layer produces a result nobody is waiting for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unexp <= 1'b0;
        end else if (fc_vld_o && tag_empty) begin
            err_unexp <= 1'b1;
        end
    end

    assign tag_pop  = fc_vld_o && !tag_empty;
    assign res_push = tag_pop && (!res_full || rs_hs);

    fc_sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (RES_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (grant_fire),
        .wr_data (rr_winner),
        .pop     (tag_pop),
        .rd_data (tag_head),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    fc_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (res_push),
        .wr_data ({tag_head, fc_dat_o}),
        .pop     (rs_hs),
        .rd_data (res_head),
        .full    (res_full),
        .empty   (res_empty)
    );

    // Only the requester named by the head tag sees a valid result.
    always_comb begin
        rs_vld = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (!res_empty && (res_head[RES_W-1 -: TAG_W] == TAG_W'(r))) rs_vld[r] = 1'b1;
        end
    end

    assign rs_dat = res_empty ? '0 : res_head[DATA_W-1:0];
    assign busy   = (state == fc_pkg::FEED) || (credits != CRED_W'(RES_DEPTH));

endmodule

// File: doc/fc_share_arb.md
FC_SHARE_ARB -- requirements
Module: fc_share_arb

Interface
REQ-001 Parameters SHALL be: DIM_INPUT, 96, input beats per sample; DIM_OUTPUT, 8, neurons per result; INPUT_W, 16, input beat width; OUTPUT_W, 8, neuron output width; N_REQ, 2, requester count; RES_DEPTH, 2, max samples in flight and result FIFO depth.
REQ-002 Ports SHALL be:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- rq_req, in, N_REQ, requester r has a full sample to send.
- rq_gnt, out, N_REQ, one-hot grant; held for the whole sample.
- rq_dat, in, N_REQ x INPUT_W, per-requester input beat.
- rq_vld, in, N_REQ, beat valid.
- fc_dat_i, out, INPUT_W, beat to the FC layer.
- fc_vld_i, out, 1, beat valid to the FC layer.
- fc_dat_o, in, DIM_OUTPUT x OUTPUT_W, FC layer result.
- fc_vld_o, in, 1, FC result valid, one-cycle pulse.
- rs_dat, out, DIM_OUTPUT x OUTPUT_W, result at the FIFO head.
- rs_vld, out, N_REQ, result valid for requester r.
- rs_rdy, in, N_REQ, requester r accepts the result.
- busy, out, 1, FSM not IDLE or a sample is in flight.
- err_unexp, out, 1, sticky flag: result arrived with no outstanding tag.

Function
REQ-003 The FSM SHALL have two states, IDLE and FEED.
REQ-004 In IDLE, if any rq_req is high and credits > 0, the block SHALL grant one requester by round-robin and enter FEED. The grant SHALL appear on the cycle after the request is sampled.
REQ-005 Round-robin SHALL search from (last_winner+1) mod N_REQ. last_winner SHALL update when a sample completes.
REQ-006 In FEED, each cycle where the granted rq_vld is high SHALL produce fc_vld_i=1 and fc_dat_i=rq_dat of the granted requester one cycle later. Cycles with rq_vld low SHALL give fc_vld_i=0, and gaps SHALL be allowed.
REQ-007 rq_vld from any non-granted requester SHALL be ignored.
REQ-008 A beat counter of ceil(log2(DIM_INPUT)) bits SHALL count accepted beats. On beat DIM_INPUT-1 the FSM SHALL return to IDLE and rq_gnt SHALL drop on the next cycle. The earliest next grant SHALL come one cycle after that.
REQ-009 The credit counter SHALL reset to RES_DEPTH, decrement at each grant, and increment at each rs handshake. If both happen in the same cycle, the count SHALL be unchanged.
REQ-010 At each grant, the winner index SHALL be pushed into a tag FIFO of depth RES_DEPTH.
REQ-011 On fc_vld_o, the block SHALL pop the tag FIFO and push {tag, fc_dat_o} into a result FIFO of depth RES_DEPTH. Credits guarantee this FIFO never overflows.
REQ-012 If fc_vld_o arrives with the tag FIFO empty, the result SHALL be dropped and err_unexp SHALL set and stay set until reset.
REQ-013 rs_vld[r] SHALL equal (result FIFO not empty AND head tag == r). rs_dat SHALL be the head data. All other rs_vld bits SHALL be 0.
REQ-014 The head SHALL pop on rs_vld[r] & rs_rdy[r]. Return order SHALL be strictly the issue order; head-of-line blocking is accepted.
REQ-015 A push and a pop on the same cycle SHALL both take effect, including when the FIFO holds one entry.
REQ-016 busy SHALL be high when the FSM is in FEED or credits < RES_DEPTH.

Reset
REQ-017 While rst_n is low, the block SHALL hold: FSM=IDLE, rq_gnt=0, fc_vld_i=0, fc_dat_i=0, rs_vld=0, rs_dat=0, busy=0, err_unexp=0, credits=RES_DEPTH, both FIFOs empty, beat counter=0, last_winner=N_REQ-1.
REQ-018 A reset in the middle of a sample SHALL abandon it, and no partial-sample state SHALL survive. FC layer results that arrive after reset SHALL set err_unexp.

Structure
REQ-019 Shared package fc_pkg SHALL hold DIM_INPUT, DIM_OUTPUT, INPUT_W, OUTPUT_W and the FSM state enum.
REQ-020 Both FIFOs SHALL be instances of one generic sub-module, fc_sync_fifo (parameters WIDTH and DEPTH; outputs full and empty; reads are first-word fall-through).

Verification
REQ-021 Single requester: rq_req[0] held, 96 beats with values 0..95 and no gaps -> rq_gnt=01 one cycle after the request, fc_dat_i=0..95 each delayed by one cycle, gnt drops after beat 95.
REQ-022 Both requesting from reset -> grants alternate 01, 10, 01, 10. Two results are returned in order, tagged 0 then 1.
REQ-023 Credit stall: rs_rdy=00, four samples requested -> only 2 grants issued, busy=1. Raise rs_rdy[0] -> third grant follows the credit return.
REQ-024 Gapped input: rq_vld toggled 1,0,1,0, rq_vld[1] driven while gnt=01 -> exactly 96 fc_vld_i pulses, requester-1 data never appears on fc_dat_i.
REQ-025 Stray fc_vld_o pulse with no samples in flight -> err_unexp=1 stays set, rs_vld stays 00.
REQ-026 Reset asserted on beat 40 of a sample -> all outputs at their reset values within the reset cycle, credits=2, next sample after reset is handled normally.
